// File: rtl/hrange_reduce.sv
// Stream reduction stage: launches an upstream generator, drains it and
// presents sum / beat count / max as a single handshaked result beat.
module hrange_reduce #(
  parameter int DATA_W = 32,
  parameter int ACC_W  = 40,
  parameter int CNT_W  = 16
) (
  input  logic                     _clock,
  input  logic                     _reset,
  input  logic                     _start,
  input  logic                     _ready,
  output logic                     _valid,
  output logic                     _done,
  output logic signed [ACC_W-1:0]  _0,
  output logic        [CNT_W-1:0]  _1,
  output logic signed [DATA_W-1:0] _2,
  output logic                     up_start,
  output logic                     up_ready,
  input  logic                     up_valid,
  input  logic                     up_done,
  input  logic signed [DATA_W-1:0] up_0,
  input  logic signed [DATA_W-1:0] up_1
);

  localparam logic signed [DATA_W-1:0] MIN =
    {1'b1, {(DATA_W-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    RUN,
    HOLD
  } state_t;

  state_t state, state_n;

  logic signed [ACC_W-1:0]  sum, sum_n, sum_a;
  logic        [CNT_W-1:0]  cnt, cnt_n, cnt_a;
  logic signed [DATA_W-1:0] mx, mx_n, mx_a;
  logic signed [ACC_W-1:0]  r0_n;
  logic        [CNT_W-1:0]  r1_n;
  logic signed [DATA_W-1:0] r2_n;

  // Running totals including the beat on the current edge, if any.
  always_comb begin
    sum_a = sum;
    cnt_a = cnt;
    mx_a  = mx;
    if (up_valid) begin
      sum_a = sum + ACC_W'(up_0);
      if (cnt != '1) cnt_a = cnt + 1'b1;
      if (up_1 > mx) mx_a = up_1;
    end
  end

  always_comb begin
    state_n = state;
    sum_n   = sum;
    cnt_n   = cnt;
    mx_n    = mx;
    r0_n    = _0;
    r1_n    = _1;
    r2_n    = _2;
    unique case (state)
      IDLE: begin
        if (_start) begin
          sum_n   = '0;
          cnt_n   = '0;
          mx_n    = MIN;
          state_n = LAUNCH;
        end
      end
      LAUNCH: state_n = RUN;
      RUN: begin
        sum_n = sum_a;
        cnt_n = cnt_a;
        mx_n  = mx_a;
        if (up_done) begin
          r0_n    = sum_a;
          r1_n    = cnt_a;
          r2_n    = mx_a;
          state_n = HOLD;
        end
      end
      HOLD: begin
        if (_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Handshake outputs are registered from the next state.
  always_ff @(posedge _clock or negedge _reset) begin
    if (!_reset) begin
      state    <= IDLE;
      sum      <= '0;
      cnt      <= '0;
      mx       <= MIN;
      _0       <= '0;
      _1       <= '0;
      _2       <= MIN;
      _valid   <= 1'b0;
      _done    <= 1'b1;
      up_start <= 1'b0;
      up_ready <= 1'b0;
    end else begin
      state    <= state_n;
      sum      <= sum_n;
      cnt      <= cnt_n;
      mx       <= mx_n;
      _0       <= r0_n;
      _1       <= r1_n;
      _2       <= r2_n;
      _valid   <= (state_n == HOLD);
      _done    <= (state_n == IDLE) || (state_n == HOLD);
      up_start <= (state_n == LAUNCH);
      up_ready <= (state_n == RUN);
    end
  end

endmodule

// File: tb/tb_hrange_reduce.sv
// Directed bench for hrange_reduce; a second narrow instance
// exercises counter saturation and accumulator wrap.
module tb_hrange_reduce;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic ready = 1'b0;
  logic up_valid = 1'b0;
  logic up_done = 1'b0;
  logic signed [31:0] up_0 = '0;
  logic signed [31:0] up_1 = '0;

  logic               valid_a, done_a, ust_a, urd_a;
  logic signed [39:0] s_a;
  logic        [15:0] c_a;
  logic signed [31:0] m_a;

  logic               valid_b, done_b, ust_b, urd_b;
  logic signed [31:0] s_b;
  logic        [1:0]  c_b;
  logic signed [31:0] m_b;

  int tests = 0;
  int fails = 0;

  localparam logic signed [63:0] MINV = -64'sd2147483648;

  always #5 clk = ~clk;

  hrange_reduce dut (
    ._clock(clk), ._reset(rst_n), ._start(start), ._ready(ready),
    ._valid(valid_a), ._done(done_a),
    ._0(s_a), ._1(c_a), ._2(m_a),
    .up_start(ust_a), .up_ready(urd_a),
    .up_valid(up_valid), .up_done(up_done),
    .up_0(up_0), .up_1(up_1)
  );

  hrange_reduce #(.DATA_W(32), .ACC_W(32), .CNT_W(2)) dut2 (
    ._clock(clk), ._reset(rst_n), ._start(start), ._ready(ready),
    ._valid(valid_b), ._done(done_b),
    ._0(s_b), ._1(c_b), ._2(m_b),
    .up_start(ust_b), .up_ready(urd_b),
    .up_valid(up_valid), .up_done(up_done),
    .up_0(up_0), .up_1(up_1)
  );

  task automatic chk(input string tag,
                     input logic signed [63:0] obs,
                     input logic signed [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic launch();
    start = 1'b1;
    cyc();
    start = 1'b0;
    chk("launch_up_start", 64'(ust_a), 1);
    chk("launch_up_ready", 64'(urd_a), 0);
    chk("launch_done", 64'(done_a), 0);
    cyc();
    chk("run_up_start", 64'(ust_a), 0);
    chk("run_up_ready", 64'(urd_a), 1);
  endtask

  task automatic beat(input logic signed [31:0] a,
                      input logic signed [31:0] b,
                      input logic d);
    up_valid = 1'b1;
    up_0 = a;
    up_1 = b;
    up_done = d;
    cyc();
    up_valid = 1'b0;
    up_done = 1'b0;
  endtask

  task automatic release_result();
    ready = 1'b1;
    cyc();
    ready = 1'b0;
  endtask

  initial begin
    // reset state
    cyc();
    cyc();
    chk("rst_valid", 64'(valid_a), 0);
    chk("rst_done", 64'(done_a), 1);
    chk("rst_up_start", 64'(ust_a), 0);
    chk("rst_up_ready", 64'(urd_a), 0);
    chk("rst_sum", 64'(s_a), 0);
    chk("rst_cnt", 64'(c_a), 0);
    chk("rst_max", 64'(m_a), MINV);
    rst_n = 1'b1;
    cyc();

    // basic stream
    launch();
    beat(0, 1, 1'b0);
    beat(2, 5, 1'b0);
    beat(4, -3, 1'b0);
    chk("basic_not_valid", 64'(valid_a), 0);
    up_done = 1'b1;
    cyc();
    up_done = 1'b0;
    chk("basic_valid", 64'(valid_a), 1);
    chk("basic_done", 64'(done_a), 1);
    chk("basic_up_ready", 64'(urd_a), 0);
    chk("basic_sum", 64'(s_a), 6);
    chk("basic_cnt", 64'(c_a), 3);
    chk("basic_max", 64'(m_a), 5);
    release_result();
    chk("basic_idle_valid", 64'(valid_a), 0);
    chk("basic_idle_done", 64'(done_a), 1);
    chk("basic_idle_hold", 64'(s_a), 6);

    // final beat with done
    launch();
    beat(10, 7, 1'b0);
    beat(20, 9, 1'b1);
    chk("last_valid", 64'(valid_a), 1);
    chk("last_sum", 64'(s_a), 30);
    chk("last_cnt", 64'(c_a), 2);
    chk("last_max", 64'(m_a), 9);
    release_result();

    // empty stream
    start = 1'b1;
    cyc();
    start = 1'b0;
    cyc();
    chk("empty_pre_valid", 64'(valid_a), 0);
    up_done = 1'b1;
    cyc();
    up_done = 1'b0;
    chk("empty_valid", 64'(valid_a), 1);
    chk("empty_sum", 64'(s_a), 0);
    chk("empty_cnt", 64'(c_a), 0);
    chk("empty_max", 64'(m_a), MINV);

    // backpressure with ignored starts
    for (int i = 0; i < 4; i++) begin
      start = 1'b1;
      cyc();
      chk("bp_valid", 64'(valid_a), 1);
      chk("bp_up_start", 64'(ust_a), 0);
      chk("bp_sum", 64'(s_a), 0);
      chk("bp_max", 64'(m_a), MINV);
    end
    start = 1'b0;
    release_result();
    chk("bp_rel_valid", 64'(valid_a), 0);
    chk("bp_rel_done", 64'(done_a), 1);
    chk("bp_rel_up_start", 64'(ust_a), 0);

    // saturation / wrap on the narrow instance
    launch();
    for (int i = 0; i < 4; i++) beat(32'sd1073741824, 0, 1'b0);
    beat(32'sd1073741824, 0, 1'b1);
    chk("sat_cnt_narrow", 64'(c_b), 3);
    chk("wrap_sum_narrow", 64'(s_b), 1073741824);
    chk("sat_valid_narrow", 64'(valid_b), 1);
    chk("wide_cnt", 64'(c_a), 5);
    chk("wide_sum", 64'(s_a), 64'sd5368709120);
    release_result();

    // asynchronous reset mid-run
    launch();
    beat(7, 3, 1'b0);
    beat(7, 3, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", 64'(valid_a), 0);
    chk("arst_done", 64'(done_a), 1);
    chk("arst_sum", 64'(s_a), 0);
    chk("arst_up_ready", 64'(urd_a), 0);
    cyc();
    rst_n = 1'b1;
    cyc();
    chk("arst_idle_up_start", 64'(ust_a), 0);
    launch();
    up_0 = 'x;
    up_1 = 'x;
    cyc();
    beat(1, 1, 1'b0);
    beat(1, 1, 1'b1);
    chk("post_sum", 64'(s_a), 2);
    chk("post_cnt", 64'(c_a), 2);
    chk("post_max", 64'(m_a), 1);
    release_result();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
